// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Multiplexed 7-segment scan controller. Digits are driven one at a time:
// each rising edge of the scan-rate wave retires the current digit, blanks
// all anodes for BLANK_CYC cycles (anti-ghosting dead time) and then drives
// the next digit. A blink-rate wave toggles a blink phase that hides digits
// whose blink bit is set. Display data is double-buffered: a ready/valid
// write fills a pending buffer, which is copied into the shadow (displayed)
// buffer only when the digit index wraps from N_DIG-1 to 0.
//
// Parameters
//   N_DIG      number of digits (2..8)
//   BLANK_CYC  dead-time cycles before each digit is driven (1..255)
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   scan_lvl    scan-rate square wave (clk domain)
//   blink_lvl   blink-rate square wave (clk domain)
//   wr_en       write request, accepted when wr_rdy = 1
//   wr_data     hex nibbles, digit i = wr_data[4i+3:4i]
//   wr_blink    per-digit blink enable
//   wr_dp       per-digit decimal point (1 = lit)
//   wr_rdy      pending buffer empty
//   an          anodes, active-low, registered
//   seg         {g,f,e,d,c,b,a}, active-low, registered
//   dp_n        decimal point, active-low, registered
//   frame_done  one-cycle pulse after the digit index wraps to 0
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int N_DIG     = 4,
  parameter int BLANK_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_lvl,
  input  logic               blink_lvl,
  input  logic               wr_en,
  input  logic [4*N_DIG-1:0] wr_data,
  input  logic [N_DIG-1:0]   wr_blink,
  input  logic [N_DIG-1:0]   wr_dp,
  output logic               wr_rdy,
  output logic [N_DIG-1:0]   an,
  output logic [6:0]         seg,
  output logic               dp_n,
  output logic               frame_done
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [7:0]       CNT_LAST = 8'(BLANK_CYC - 1);
  localparam logic [N_DIG-1:0] DIG_ONE  = {{(N_DIG-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Active-low hex decode; unknown codes blank the digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] code;
    case (hex)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      4'hA:    code = 7'h08;
      4'hB:    code = 7'h03;
      4'hC:    code = 7'h46;
      4'hD:    code = 7'h21;
      4'hE:    code = 7'h06;
      4'hF:    code = 7'h0E;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  // State registers
  state_t               state_r, state_nx;
  logic [7:0]           cnt_r, cnt_nx;
  logic [IDX_W-1:0]     idx_r, idx_nx;
  logic                 scan_prev_r, blink_prev_r;
  logic                 blink_ph_r, blink_ph_nx;
  logic [4*N_DIG-1:0]   shadow_data_r, shadow_data_nx;
  logic [N_DIG-1:0]     shadow_blink_r, shadow_blink_nx;
  logic [N_DIG-1:0]     shadow_dp_r, shadow_dp_nx;
  logic [4*N_DIG-1:0]   pend_data_r, pend_data_nx;
  logic [N_DIG-1:0]     pend_blink_r, pend_blink_nx;
  logic [N_DIG-1:0]     pend_dp_r, pend_dp_nx;
  logic                 wr_rdy_r, wr_rdy_nx;
  logic [N_DIG-1:0]     an_r, an_nx;
  logic [6:0]           seg_r, seg_nx;
  logic                 dp_n_r, dp_n_nx;
  logic                 frame_done_r;

  logic                 scan_edge_s, blink_edge_s, wrap_s;
  logic [3:0]           nibble_s;

  assign scan_edge_s  = scan_lvl  & ~scan_prev_r;
  assign blink_edge_s = blink_lvl & ~blink_prev_r;

  // Scan sequencer: dead-time counting, digit advance and wrap detection.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    idx_nx   = idx_r;
    wrap_s   = 1'b0;
    case (state_r)
      ST_BLANK: begin
        // Scan edges arriving here are intentionally ignored.
        if (cnt_r == CNT_LAST) begin
          cnt_nx   = 8'd0;
          state_nx = ST_DRIVE;
        end else begin
          cnt_nx = cnt_r + 8'd1;
        end
      end
      ST_DRIVE: begin
        if (scan_edge_s) begin
          state_nx = ST_BLANK;
          cnt_nx   = 8'd0;
          if (idx_r == IDX_LAST) begin
            idx_nx = '0;
            wrap_s = 1'b1;
          end else begin
            idx_nx = idx_r + IDX_ONE;
          end
        end else begin
          state_nx = ST_DRIVE;
        end
      end
      default: begin
        state_nx = ST_BLANK;
        cnt_nx   = 8'd0;
        idx_nx   = '0;
      end
    endcase
  end

  // Blink phase and double-buffer handshake.
  always_comb begin
    shadow_data_nx  = shadow_data_r;
    shadow_blink_nx = shadow_blink_r;
    shadow_dp_nx    = shadow_dp_r;
    pend_data_nx    = pend_data_r;
    pend_blink_nx   = pend_blink_r;
    pend_dp_nx      = pend_dp_r;
    wr_rdy_nx       = wr_rdy_r;
    if (blink_edge_s) begin
      blink_ph_nx = ~blink_ph_r;
    end else begin
      blink_ph_nx = blink_ph_r;
    end
    // Commit and accept are mutually exclusive: commit needs a full
    // pending buffer, accept needs an empty one. A write landing on a
    // wrap cycle therefore waits for the next wrap.
    if (wrap_s && !wr_rdy_r) begin
      shadow_data_nx  = pend_data_r;
      shadow_blink_nx = pend_blink_r;
      shadow_dp_nx    = pend_dp_r;
      wr_rdy_nx       = 1'b1;
    end else if (wr_en && wr_rdy_r) begin
      pend_data_nx  = wr_data;
      pend_blink_nx = wr_blink;
      pend_dp_nx    = wr_dp;
      wr_rdy_nx     = 1'b0;
    end else begin
      wr_rdy_nx = wr_rdy_r;
    end
  end

  // Output decode from next-state values so the registered outputs track
  // the state each cycle without an extra cycle of lag.
  always_comb begin
    an_nx    = '1;
    seg_nx   = 7'h7F;
    dp_n_nx  = 1'b1;
    nibble_s = shadow_data_nx[{idx_nx, 2'b00} +: 4];
    if (state_nx == ST_DRIVE && !(shadow_blink_nx[idx_nx] && blink_ph_nx)) begin
      an_nx   = ~(DIG_ONE << idx_nx);
      seg_nx  = hex_to_seg(nibble_s);
      dp_n_nx = ~shadow_dp_nx[idx_nx];
    end else begin
      an_nx = '1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_BLANK;
      cnt_r          <= 8'd0;
      idx_r          <= '0;
      scan_prev_r    <= scan_lvl;
      blink_prev_r   <= blink_lvl;
      blink_ph_r     <= 1'b0;
      shadow_data_r  <= '0;
      shadow_blink_r <= '0;
      shadow_dp_r    <= '0;
      pend_data_r    <= '0;
      pend_blink_r   <= '0;
      pend_dp_r      <= '0;
      wr_rdy_r       <= 1'b1;
      an_r           <= '1;
      seg_r          <= 7'h7F;
      dp_n_r         <= 1'b1;
      frame_done_r   <= 1'b0;
    end else begin
      state_r        <= state_nx;
      cnt_r          <= cnt_nx;
      idx_r          <= idx_nx;
      scan_prev_r    <= scan_lvl;
      blink_prev_r   <= blink_lvl;
      blink_ph_r     <= blink_ph_nx;
      shadow_data_r  <= shadow_data_nx;
      shadow_blink_r <= shadow_blink_nx;
      shadow_dp_r    <= shadow_dp_nx;
      pend_data_r    <= pend_data_nx;
      pend_blink_r   <= pend_blink_nx;
      pend_dp_r      <= pend_dp_nx;
      wr_rdy_r       <= wr_rdy_nx;
      an_r           <= an_nx;
      seg_r          <= seg_nx;
      dp_n_r         <= dp_n_nx;
      frame_done_r   <= wrap_s;
    end
  end

  assign wr_rdy     = wr_rdy_r;
  assign an         = an_r;
  assign seg        = seg_r;
  assign dp_n       = dp_n_r;
  assign frame_done = frame_done_r;

endmodule
